cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multi-cycle control unit for the 16-bit processor: fetches instructions over a req/ack instruction-memory port, latches them into the instruction register, decodes them, and issues one-hot strobes to the 8×8-bit register file, the ALU and the 256-byte data memory. It sits between the instruction ROM, the data memory and the existing register-file/ALU datapath. It replaces free-running, every-clock fetch with a handshaked fetch-decode-execute-writeback sequence that tolerates wait states.

## Interface
- PC_W, 8, program-counter and instruction-address width; PC wraps modulo 2^PC_W
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and clears all registers
- start  in  1  sampled in IDLE/HALT: begin execution at PC 0
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (= pc)
- imem_ack  in  1  fetch complete; imem_data valid this cycle
- imem_data  in  16  instruction word
- ir  out  16  latched instruction
- pc  out  PC_W  program counter (next fetch address)
- rf_ra1, rf_ra2  out  3 each  register-file read addresses
- rf_we  out  1  register-file write strobe
- rf_wa  out  3  write address
- rf_wsel  out  2  write source: 00 ALU result, 01 ir[7:0] immediate, 10 datapath MDR
- alu_en  out  1  ALU execute/flag-update strobe
- alu_op  out  3  ALU function (ir[14:12])
- dmem_req  out  1  data-memory request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  8  data-memory address (ir[7:0])
- dmem_ack  in  1  data access complete; the datapath captures dmem_rdata into the MDR on this cycle
- busy  out  1  state is not IDLE or HALT
- halted  out  1  state is HALT
- illegal  out  1  sticky: last halt was caused by an undefined opcode

## Operation
- Decode, by ir[15:12]:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR → ALU class; dest ir[11:9], src1 ir[8:6], src2 ir[5:3].
  - 1000 LDI: r[ir[11:9]] ← ir[7:0].
  - 1001 LD: r[ir[11:9]] ← mem[ir[7:0]].
  - 1010 ST: mem[ir[7:0]] ← r[ir[11:9]].
  - 1111 HALT.
  - All other codes are illegal.
- FSM states: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: all strobes 0. On start=1 → FETCH, pc←0, illegal←0.
- FETCH: imem_req=1, imem_addr=pc, both held stable until imem_ack is sampled high. Then ir←imem_data, pc←pc+1 (wraps), → DECODE.
- DECODE: one cycle.
  - rf_ra1=ir[8:6] and rf_ra2=ir[5:3]; for ST, rf_ra1=ir[11:9].
  - ALU class → EXEC; LDI → WB; LD/ST → MEM; HALT → HALT; illegal → HALT with illegal←1.
- EXEC: one cycle, alu_en=1, alu_op=ir[14:12], read addresses held → WB.
- MEM: dmem_req=1, dmem_addr=ir[7:0], dmem_we=(opcode==1010), held stable until dmem_ack. Then ST → FETCH, LD → WB.
- WB: one cycle, rf_we=1, rf_wa=ir[11:9], rf_wsel = 00 (ALU) / 01 (LDI) / 10 (LD) → FETCH.
- HALT: halted=1, no strobes. start=1 → FETCH with pc←0, illegal←0. Otherwise remain.
- start is ignored while busy.
- The undefined ALU codes 0100–0111 are illegal.
- No instruction writes the register file more than once; rf_we, alu_en, dmem_req and imem_req are never high together.

## Timing
- Moore outputs: all outputs are functions of registered state, ir and pc only; no combinational input-to-output path.
- Reset (asynchronous, immediate): state=IDLE, pc=0, ir=0, every strobe 0, busy=0, halted=0, illegal=0.
- Reset asserted mid-FETCH or mid-MEM drops req the same instant. No completion is required from memory.
- With zero-wait acks (ack high on the first req cycle):
  - LDI and ST take 3 cycles.
  - ALU ops and LD take 4 cycles.
  - HALT enters HALT 2 cycles after entering FETCH.
- Each wait cycle adds exactly one cycle.
- An ack is counted only on an edge where the matching req is high. Acks outside FETCH/MEM are ignored.
- pc increments on the fetch-ack edge. Fetch from address 2^PC_W−1 leaves pc=0.

## Test plan
- Program at 0..8: 0x8007, 0x8202, 0x8408, 0x8601, 0x0E08, 0x0C98, 0xAEFF, 0xACFE, 0xF000; both acks tied high; start pulsed.
  - halted rises exactly 28 cycles after FETCH is entered.
  - Writes observed: mem[FF]=09, mem[FE]=09.
  - Exactly 6 rf_we pulses with wa 0,1,2,3,7,6.
  - illegal=0.
- Same program with imem_ack delayed 2 cycles and dmem_ack delayed 3 cycles on every access.
  - Completion takes 28+18+6=52 cycles.
  - req, address and we are stable throughout each wait.
- Instruction 0x4000 at pc 0 → HALT after 2 cycles with illegal=1 and no rf_we/alu_en/dmem_req. A subsequent start clears illegal.
- LD 0x9A10 with the MDR returning 0x5A → dmem_req with we=0, addr=0x10, then WB with rf_wa=5, rf_wsel=10.
- Reset asserted during MEM of a ST while dmem_ack is held low → all outputs 0 asynchronously, state IDLE, pc=0. The next start refetches from 0.
- PC_W=3, eight LDIs with no HALT → pc wraps 7→0 and fetch continues at address 0. start is ignored while busy.

Source files
------------

// File: rtl/cpu_sequencer_if.sv
// Bus bundle between the cpu_sequencer and its instruction/data memories and datapath.
// master = sequencer side, slave = memories/datapath side.
interface cpu_sequencer_if #(
  parameter int PC_W = 8
);
  logic            start;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_data;
  logic [15:0]     ir;
  logic [PC_W-1:0] pc;
  logic [2:0]      rf_ra1;
  logic [2:0]      rf_ra2;
  logic            rf_we;
  logic [2:0]      rf_wa;
  logic [1:0]      rf_wsel;
  logic            alu_en;
  logic [2:0]      alu_op;
  logic            dmem_req;
  logic            dmem_we;
  logic [7:0]      dmem_addr;
  logic            dmem_ack;
  logic            busy;
  logic            halted;
  logic            illegal;

  modport master (
    input  start, imem_ack, imem_data, dmem_ack,
    output imem_req, imem_addr, ir, pc, rf_ra1, rf_ra2, rf_we, rf_wa, rf_wsel,
           alu_en, alu_op, dmem_req, dmem_we, dmem_addr, busy, halted, illegal
  );

  modport slave (
    output start, imem_ack, imem_data, dmem_ack,
    input  imem_req, imem_addr, ir, pc, rf_ra1, rf_ra2, rf_we, rf_wa, rf_wsel,
           alu_en, alu_op, dmem_req, dmem_we, dmem_addr, busy, halted, illegal
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer with req/ack memory handshakes.
// Every output is registered from the next-state values, so there is no input-to-output path.
module cpu_sequencer #(
  parameter int PC_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  cpu_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [15:0]     r_ir;
  logic [15:0]     w_ir_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic            r_illegal;
  logic            w_illegal_nxt;

  logic            r_imem_req;
  logic [2:0]      r_rf_ra1;
  logic [2:0]      r_rf_ra2;
  logic            r_rf_we;
  logic [2:0]      r_rf_wa;
  logic [1:0]      r_rf_wsel;
  logic            r_alu_en;
  logic [2:0]      r_alu_op;
  logic            r_dmem_req;
  logic            r_dmem_we;
  logic [7:0]      r_dmem_addr;
  logic            r_busy;
  logic            r_halted;

  logic [3:0]      w_op;
  logic [3:0]      w_op_nxt;
  logic            w_rd_hold;
  logic [1:0]      w_wsel_nxt;

  assign w_op     = r_ir[15:12];
  assign w_op_nxt = w_ir_nxt[15:12];

  always_comb begin
    w_state_nxt   = r_state;
    w_ir_nxt      = r_ir;
    w_pc_nxt      = r_pc;
    w_illegal_nxt = r_illegal;
    case (r_state)
      S_IDLE, S_HALT: begin
        if (bus.start) begin
          w_state_nxt   = S_FETCH;
          w_pc_nxt      = '0;
          w_illegal_nxt = 1'b0;
        end
      end
      S_FETCH: begin
        if (bus.imem_ack) begin
          w_state_nxt = S_DECODE;
          w_ir_nxt    = bus.imem_data;
          w_pc_nxt    = r_pc + PC_W'(1);
        end
      end
      S_DECODE: begin
        case (w_op)
          4'h0, 4'h1, 4'h2, 4'h3: w_state_nxt = S_EXEC;
          OP_LDI:                 w_state_nxt = S_WB;
          OP_LD, OP_ST:           w_state_nxt = S_MEM;
          OP_HALT:                w_state_nxt = S_HALT;
          default: begin
            w_state_nxt   = S_HALT;
            w_illegal_nxt = 1'b1;
          end
        endcase
      end
      S_EXEC: w_state_nxt = S_WB;
      S_MEM: begin
        if (bus.dmem_ack) begin
          w_state_nxt = (w_op == OP_ST) ? S_FETCH : S_WB;
        end
      end
      S_WB:    w_state_nxt = S_FETCH;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Read addresses stay valid from DECODE through MEM so ST data is available at the ack.
  always_comb begin
    w_rd_hold = (w_state_nxt == S_DECODE) || (w_state_nxt == S_EXEC) || (w_state_nxt == S_MEM);
    case (w_op_nxt)
      OP_LDI:  w_wsel_nxt = 2'b01;
      OP_LD:   w_wsel_nxt = 2'b10;
      default: w_wsel_nxt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ir        <= '0;
      r_pc        <= '0;
      r_illegal   <= 1'b0;
      r_imem_req  <= 1'b0;
      r_rf_ra1    <= '0;
      r_rf_ra2    <= '0;
      r_rf_we     <= 1'b0;
      r_rf_wa     <= '0;
      r_rf_wsel   <= '0;
      r_alu_en    <= 1'b0;
      r_alu_op    <= '0;
      r_dmem_req  <= 1'b0;
      r_dmem_we   <= 1'b0;
      r_dmem_addr <= '0;
      r_busy      <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ir        <= w_ir_nxt;
      r_pc        <= w_pc_nxt;
      r_illegal   <= w_illegal_nxt;
      r_imem_req  <= (w_state_nxt == S_FETCH);
      r_rf_ra1    <= w_rd_hold ? ((w_op_nxt == OP_ST) ? w_ir_nxt[11:9] : w_ir_nxt[8:6]) : 3'd0;
      r_rf_ra2    <= w_rd_hold ? w_ir_nxt[5:3] : 3'd0;
      r_alu_en    <= (w_state_nxt == S_EXEC);
      r_alu_op    <= (w_state_nxt == S_EXEC) ? w_ir_nxt[14:12] : 3'd0;
      r_dmem_req  <= (w_state_nxt == S_MEM);
      r_dmem_we   <= (w_state_nxt == S_MEM) && (w_op_nxt == OP_ST);
      r_dmem_addr <= (w_state_nxt == S_MEM) ? w_ir_nxt[7:0] : 8'd0;
      r_rf_we     <= (w_state_nxt == S_WB);
      r_rf_wa     <= (w_state_nxt == S_WB) ? w_ir_nxt[11:9] : 3'd0;
      r_rf_wsel   <= (w_state_nxt == S_WB) ? w_wsel_nxt : 2'b00;
      r_busy      <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_HALT);
      r_halted    <= (w_state_nxt == S_HALT);
    end
  end

  assign bus.imem_req  = r_imem_req;
  assign bus.imem_addr = r_pc;
  assign bus.ir        = r_ir;
  assign bus.pc        = r_pc;
  assign bus.rf_ra1    = r_rf_ra1;
  assign bus.rf_ra2    = r_rf_ra2;
  assign bus.rf_we     = r_rf_we;
  assign bus.rf_wa     = r_rf_wa;
  assign bus.rf_wsel   = r_rf_wsel;
  assign bus.alu_en    = r_alu_en;
  assign bus.alu_op    = r_alu_op;
  assign bus.dmem_req  = r_dmem_req;
  assign bus.dmem_we   = r_dmem_we;
  assign bus.dmem_addr = r_dmem_addr;
  assign bus.busy      = r_busy;
  assign bus.halted    = r_halted;
  assign bus.illegal   = r_illegal;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: memory responders with programmable wait states,
// a small register-file/ALU/data-memory model, and assertions at each check point.
module tb_cpu_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset3 = 1'b1;
  always #5 clk = ~clk;

  cpu_sequencer_if #(.PC_W(8)) bus ();
  cpu_sequencer_if #(.PC_W(3)) bus3 ();

  cpu_sequencer #(.PC_W(8)) dut  (.clk(clk), .reset(reset),  .bus(bus.master));
  cpu_sequencer #(.PC_W(3)) dut3 (.clk(clk), .reset(reset3), .bus(bus3.master));

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] prog  [0:255];
  logic [15:0] prog3 [0:7];
  logic imem_tie = 1'b1, dmem_tie = 1'b1, dmem_block = 1'b0;
  int   idly = 0, ddly = 0;
  int   icnt = 0, dcnt = 0;

  assign bus.imem_data  = prog[bus.imem_addr];
  assign bus.imem_ack   = imem_tie | (bus.imem_req && icnt == idly);
  assign bus.dmem_ack   = !dmem_block && (dmem_tie | (bus.dmem_req && dcnt == ddly));
  assign bus3.imem_data = prog3[bus3.imem_addr];
  assign bus3.imem_ack  = 1'b1;
  assign bus3.dmem_ack  = 1'b1;

  always @(posedge clk) begin
    icnt <= (bus.imem_req && !bus.imem_ack) ? icnt + 1 : 0;
    dcnt <= (bus.dmem_req && !bus.dmem_ack) ? dcnt + 1 : 0;
  end

  // datapath model: register file, ALU result latch, MDR, data memory
  logic [7:0] rf   [0:7];
  logic [7:0] dmem [0:255];
  logic [7:0] alu_y, mdr;
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
      for (int i = 0; i < 256; i++) dmem[i] <= 8'h00;
      dmem[8'h10] <= 8'h5A;
      alu_y <= 8'h00;
      mdr   <= 8'h00;
    end else begin
      if (bus.alu_en) begin
        case (bus.alu_op)
          3'd0:    alu_y <= rf[bus.rf_ra1] + rf[bus.rf_ra2];
          3'd1:    alu_y <= rf[bus.rf_ra1] - rf[bus.rf_ra2];
          3'd2:    alu_y <= rf[bus.rf_ra1] & rf[bus.rf_ra2];
          default: alu_y <= rf[bus.rf_ra1] | rf[bus.rf_ra2];
        endcase
      end
      if (bus.dmem_req && bus.dmem_ack) begin
        if (bus.dmem_we) dmem[bus.dmem_addr] <= rf[bus.rf_ra1];
        else             mdr <= dmem[bus.dmem_addr];
      end
      if (bus.rf_we) begin
        case (bus.rf_wsel)
          2'b00:   rf[bus.rf_wa] <= alu_y;
          2'b01:   rf[bus.rf_wa] <= bus.ir[7:0];
          default: rf[bus.rf_wa] <= mdr;
        endcase
      end
    end
  end

  int n_we, n_alu, n_dreq, n_overlap, n_unstable, n_iwait, n_dwait;
  logic [2:0] wa_log [0:15];
  logic p_iwait, p_dwait, p_dwe;
  logic [7:0] p_iaddr, p_daddr;
  always @(negedge clk) begin
    if (reset) begin
      n_we <= 0; n_alu <= 0; n_dreq <= 0; n_overlap <= 0; n_unstable <= 0;
      n_iwait <= 0; n_dwait <= 0; p_iwait <= 1'b0; p_dwait <= 1'b0;
      p_dwe <= 1'b0; p_iaddr <= 8'h00; p_daddr <= 8'h00;
    end else begin
      if (bus.rf_we) begin
        wa_log[n_we[3:0]] <= bus.rf_wa;
        n_we <= n_we + 1;
      end
      if (bus.alu_en)   n_alu  <= n_alu + 1;
      if (bus.dmem_req) n_dreq <= n_dreq + 1;
      if (int'(bus.rf_we) + int'(bus.alu_en) + int'(bus.dmem_req) + int'(bus.imem_req) > 1)
        n_overlap <= n_overlap + 1;
      if (p_iwait && (!bus.imem_req || bus.imem_addr != p_iaddr)) n_unstable <= n_unstable + 1;
      if (p_dwait && (!bus.dmem_req || bus.dmem_addr != p_daddr || bus.dmem_we != p_dwe))
        n_unstable <= n_unstable + 1;
      if (bus.imem_req && !bus.imem_ack) n_iwait <= n_iwait + 1;
      if (bus.dmem_req && !bus.dmem_ack) n_dwait <= n_dwait + 1;
      p_iwait <= bus.imem_req && !bus.imem_ack;
      p_dwait <= bus.dmem_req && !bus.dmem_ack;
      p_iaddr <= bus.imem_addr;
      p_daddr <= bus.dmem_addr;
      p_dwe   <= bus.dmem_we;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_default();
    for (int i = 0; i < 256; i++) prog[i] = 16'hF000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // pulse start; cyc counts negedges from the first FETCH cycle until halted is seen
  task automatic run_to_halt(input int limit, output int cyc);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.halted && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  int cyc;

  initial begin
    bus.start  = 1'b0;
    bus3.start = 1'b0;
    for (int i = 0; i < 8; i++) prog3[i] = {4'h8, 3'(i), 1'b0, 8'(i + 1)};

    // ---- main program, zero-wait acks ----
    load_default();
    prog[0] = 16'h8007; prog[1] = 16'h8202; prog[2] = 16'h8408; prog[3] = 16'h8601;
    prog[4] = 16'h0E08; prog[5] = 16'h0C98; prog[6] = 16'hAEFF; prog[7] = 16'hACFE;
    prog[8] = 16'hF000;
    imem_tie = 1'b1; dmem_tie = 1'b1;
    @(negedge clk);
    chk("rst_pc",      32'(bus.pc), 32'h0);
    chk("rst_ir",      32'(bus.ir), 32'h0);
    chk("rst_busy",    32'(bus.busy), 32'h0);
    chk("rst_halted",  32'(bus.halted), 32'h0);
    chk("rst_illegal", 32'(bus.illegal), 32'h0);
    chk("rst_strobes", 32'({bus.imem_req, bus.dmem_req, bus.rf_we, bus.alu_en}), 32'h0);
    do_reset();
    chk("idle_pc_with_ack", 32'(bus.pc), 32'h0);
    run_to_halt(200, cyc);
    chk("prog_cycles",  32'(cyc), 32'd28);
    chk("prog_ff",      32'(dmem[8'hFF]), 32'h09);
    chk("prog_fe",      32'(dmem[8'hFE]), 32'h09);
    chk("prog_n_we",    32'(n_we), 32'd6);
    chk("prog_wa_seq",  32'({wa_log[0], wa_log[1], wa_log[2], wa_log[3], wa_log[4], wa_log[5]}),
        32'({3'd0, 3'd1, 3'd2, 3'd3, 3'd7, 3'd6}));
    chk("prog_illegal", 32'(bus.illegal), 32'h0);
    chk("prog_pc",      32'(bus.pc), 32'd9);
    chk("prog_overlap", 32'(n_overlap), 32'd0);

    // ---- same program with wait states ----
    imem_tie = 1'b0; dmem_tie = 1'b0; idly = 2; ddly = 3;
    do_reset();
    run_to_halt(400, cyc);
    chk("wait_cycles",   32'(cyc), 32'd52);
    chk("wait_unstable", 32'(n_unstable), 32'd0);
    chk("wait_iwait",    32'(n_iwait), 32'd18);
    chk("wait_dwait",    32'(n_dwait), 32'd6);
    chk("wait_ff",       32'(dmem[8'hFF]), 32'h09);
    chk("wait_fe",       32'(dmem[8'hFE]), 32'h09);
    chk("wait_n_we",     32'(n_we), 32'd6);
    chk("wait_overlap",  32'(n_overlap), 32'd0);

    // ---- illegal opcode ----
    imem_tie = 1'b1; dmem_tie = 1'b1; idly = 0; ddly = 0;
    load_default();
    prog[0] = 16'h4000;
    do_reset();
    run_to_halt(50, cyc);
    chk("ill_cycles",  32'(cyc), 32'd2);
    chk("ill_flag",    32'(bus.illegal), 32'h1);
    chk("ill_strobes", 32'(n_we + n_alu + n_dreq), 32'd0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("ill_clear",   32'(bus.illegal), 32'h0);
    chk("ill_refetch", 32'({bus.imem_req, bus.imem_addr}), 32'({1'b1, 8'h00}));
    cyc = 0;
    while (!bus.halted && cyc < 50) begin @(negedge clk); cyc++; end
    chk("ill_again",   32'({bus.halted, bus.illegal}), 32'h3);

    // ---- LD ----
    load_default();
    prog[0] = 16'h9A10;
    do_reset();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("ld_mem", 32'({bus.dmem_req, bus.dmem_we, bus.dmem_addr}), 32'({1'b1, 1'b0, 8'h10}));
    @(negedge clk);
    chk("ld_wb",  32'({bus.rf_we, bus.rf_wa, bus.rf_wsel}), 32'({1'b1, 3'd5, 2'b10}));
    cyc = 0;
    while (!bus.halted && cyc < 50) begin @(negedge clk); cyc++; end
    chk("ld_rf5", 32'(rf[5]), 32'h5A);

    // ---- reset during ST wait ----
    load_default();
    prog[0] = 16'hAEFF;
    dmem_block = 1'b1;
    do_reset();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("st_wait", 32'({bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.busy}),
        32'({1'b1, 1'b1, 8'hFF, 1'b1}));
    #2 reset = 1'b1;
    #1;
    chk("async_strobes", 32'({bus.imem_req, bus.dmem_req, bus.dmem_we, bus.rf_we, bus.alu_en}), 32'h0);
    chk("async_dmaddr",  32'(bus.dmem_addr), 32'h0);
    chk("async_state",   32'({bus.busy, bus.halted, bus.illegal}), 32'h0);
    chk("async_pc_ir",   32'({bus.pc, bus.ir}), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    dmem_block = 1'b0;
    @(negedge clk);
    run_to_halt(50, cyc);
    chk("st_refetch_cyc", 32'(cyc), 32'd5);
    chk("st_refetch_pc",  32'(bus.pc), 32'd2);

    // ---- PC_W = 3 wrap, start ignored while busy ----
    @(negedge clk);
    reset3 = 1'b0;
    @(negedge clk);
    chk("w3_reset", 32'({bus3.pc, bus3.busy}), 32'h0);
    bus3.start = 1'b1;
    @(negedge clk);
    bus3.start = 1'b0;
    chk("w3_c0", 32'({bus3.imem_req, bus3.imem_addr}), 32'({1'b1, 3'd0}));
    repeat (3) @(negedge clk);
    bus3.start = 1'b1;
    @(negedge clk);
    bus3.start = 1'b0;
    chk("w3_start_ignored", 32'({bus3.imem_req, bus3.busy, bus3.pc}), 32'({1'b0, 1'b1, 3'd2}));
    @(negedge clk);
    chk("w3_c5_wb", 32'({bus3.rf_we, bus3.rf_wa}), 32'({1'b1, 3'd1}));
    repeat (16) @(negedge clk);
    chk("w3_c21", 32'({bus3.imem_req, bus3.imem_addr}), 32'({1'b1, 3'd7}));
    @(negedge clk);
    chk("w3_c22", 32'({bus3.pc, bus3.ir}), 32'({3'd0, prog3[7]}));
    repeat (2) @(negedge clk);
    chk("w3_c24", 32'({bus3.imem_req, bus3.imem_addr}), 32'({1'b1, 3'd0}));
    @(negedge clk);
    chk("w3_c25", 32'({bus3.pc, bus3.ir}), 32'({3'd1, prog3[0]}));
    reset3 = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
